// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: multi-cycle add/subtract unit. Each clock adds one
// DIGIT-bit slice of the operands, least significant slice first, and keeps
// the carry in a flop between slices. Valid/ready handshakes are used on
// both the operand side and the result side.
`timescale 1ns/1ps
module serial_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(N - 1);

    // The slice width must divide the operand width exactly.
    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("serial_chunk_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [DIGIT-1:0] w_a_slice;
    logic [DIGIT-1:0] w_b_slice;
    logic [DIGIT:0]   w_slice_sum;
    logic             w_carry_into_msb;
    logic             w_last;

    // Slice adder: DIGIT-bit ripple of the current operand slices plus the stored carry.
    always_comb begin
        w_a_slice        = r_a[r_cnt*DIGIT +: DIGIT];
        w_b_slice        = r_b[r_cnt*DIGIT +: DIGIT];
        w_slice_sum      = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{DIGIT{1'b0}}, r_carry};
        // Carry entering the top bit of the slice, recovered from the sum bit.
        w_carry_into_msb = w_slice_sum[DIGIT-1] ^ w_a_slice[DIGIT-1] ^ w_b_slice[DIGIT-1];
        w_last           = (r_cnt == LAST_SLICE);
    end

    // Next-state decode for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                // Release goes back to IDLE only; no accept in the same cycle.
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, per-slice accumulation and final flag registration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= {CW{1'b0}};
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_sum   <= {WIDTH{1'b0}};
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1: invert B and seed the carry.
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= sub;
                        r_cnt   <= {CW{1'b0}};
                        r_sum   <= {WIDTH{1'b0}};
                    end
                end
                S_RUN: begin
                    r_sum[r_cnt*DIGIT +: DIGIT] <= w_slice_sum[DIGIT-1:0];
                    r_carry                     <= w_slice_sum[DIGIT];
                    r_cnt                       <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (w_last) begin
                        r_cout <= w_slice_sum[DIGIT];
                        r_ovf  <= w_carry_into_msb ^ w_slice_sum[DIGIT];
                    end
                end
                S_DONE: begin
                    // Result held until the consumer takes it.
                end
                default: begin
                    r_cnt <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
